// File: rtl/bram_rd_pkg.sv
// Shared types and constants for the block-RAM burst reader.
//   ADDR_W    : RAM address width (2048 words)
//   DATA_W    : RAM word width
//   BUF_DEPTH : output buffer entries (only 2 is supported)
//   state_e   : reader FSM state
//   buf_entry_t : one output buffer entry {data, last}
package bram_rd_pkg;

    localparam int unsigned ADDR_W    = 11;
    localparam int unsigned DATA_W    = 2;
    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } buf_entry_t;

endpackage

// File: rtl/bram_s2_burst_reader_if.sv
// Bundle of the command, RAM-port and output-stream signals of the burst reader.
//   master : the reader (drives cmd_ready, RAM addr/en/we/rst, stream o_*)
//   slave  : the environment (command source, RAM, stream consumer)
// Signals:
//   cmd_valid/cmd_ready/cmd_addr/cmd_len : burst command handshake
//   addr/en/we/rst/dout                  : RAM port (dout = RAM DO, 1-cycle latency)
//   o_valid/o_ready/o_data/o_last        : output word stream
interface bram_s2_burst_reader_if;
    import bram_rd_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;

    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              we;
    logic              rst;
    logic [DATA_W-1:0] dout;

    logic              o_valid;
    logic              o_ready;
    logic [DATA_W-1:0] o_data;
    logic              o_last;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, dout, o_ready,
        output cmd_ready, addr, en, we, rst, o_valid, o_data, o_last
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, dout, o_ready,
        input  cmd_ready, addr, en, we, rst, o_valid, o_data, o_last
    );

endinterface

// File: rtl/bram_rd_skid_fifo.sv
// Two-entry synchronous FIFO holding captured RAM words for the output stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush_i    : synchronous clear of all entries (wins over push/pop)
//   push_i     : write wdata_i
//   wdata_i    : entry to write
//   pop_i      : drop the head entry
//   rdata_o    : head entry
//   count_o    : number of valid entries (0..2)
module bram_rd_skid_fifo
    import bram_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_i,
    input  logic       push_i,
    input  buf_entry_t wdata_i,
    input  logic       pop_i,
    output buf_entry_t rdata_o,
    output logic [1:0] count_o
);

    buf_entry_t mem_q [BUF_DEPTH];
    logic       wptr_q;
    logic       rptr_q;
    logic [1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush_i) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= ~wptr_q;
            end
            if (pop_i) begin
                rptr_q <= ~rptr_q;
            end
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = cnt_q;

    // The reader's credit rule must make these impossible.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i) begin
            assert (!(push_i && !pop_i && cnt_q == 2'd2));
            assert (!(pop_i && cnt_q == 2'd0));
        end
    end

endmodule

// File: rtl/bram_s2_burst_reader.sv
// Burst read master for one port of the 2-bit x 2048 dual-port block RAM.
// Takes a (start address, length-1) command, issues one RAM read per cycle while
// output credit allows, captures DO one cycle after EN and streams the words out
// through a 2-entry buffer with valid/ready and a last marker.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command / RAM port / output stream (master side)
//   abort_i    : one-cycle pulse, cancels the active burst
//   busy_o     : high whenever the FSM is not idle
// Optional build macro BRAM_RD_STATS_EN adds:
//   stat_clr_i    : synchronous clear of both statistics counters
//   stat_words_o  : saturating count of words popped
//   stat_stalls_o : saturating count of cycles with o_valid=1 and o_ready=0
module bram_s2_burst_reader
    import bram_rd_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    bram_s2_burst_reader_if.master bus,
    input  logic                   abort_i,
    output logic                   busy_o
`ifdef BRAM_RD_STATS_EN
    ,
    input  logic                   stat_clr_i,
    output logic [31:0]            stat_words_o,
    output logic [31:0]            stat_stalls_o
`endif
);

    state_e            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic              inflight_q;
    logic              inflight_last_q;

    buf_entry_t        head;
    buf_entry_t        wentry;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;
    logic              o_valid;
    logic              pop;
    logic              issue_ok;
    logic              en;
    logic              flush;

    assign o_valid = (buf_cnt != 2'd0);
    assign pop     = o_valid & bus.o_ready;

    // Words already owed to the buffer after this cycle's pop; issuing is only
    // allowed while that leaves room, so the buffer can never overflow.
    assign occ      = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue_ok = (occ < 3'd2);
    assign en       = (state_q == StRun) && issue_ok;
    assign flush    = (state_q != StIdle) && abort_i;

    assign wentry.data = bus.dout;
    assign wentry.last = inflight_last_q;

    bram_rd_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (inflight_q),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .count_o (buf_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            remain_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            // An abort drops the word the RAM is returning next cycle.
            inflight_q      <= en && !abort_i;
            inflight_last_q <= en && (remain_q == '0);
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid) begin
                        state_q  <= StRun;
                        addr_q   <= bus.cmd_addr;
                        remain_q <= bus.cmd_len;
                    end
                end
                StRun: begin
                    if (abort_i) begin
                        state_q <= StIdle;
                    end else if (en) begin
                        addr_q   <= addr_q + ADDR_W'(1);
                        remain_q <= remain_q - ADDR_W'(1);
                        if (remain_q == '0) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (abort_i || (pop && head.last)) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.cmd_ready = (state_q == StIdle);
    assign busy_o        = (state_q != StIdle);
    assign bus.addr      = addr_q;
    assign bus.en        = en;
    assign bus.we        = 1'b0;
    assign bus.rst       = 1'b0;
    assign bus.o_valid   = o_valid;
    // Gate with valid so stale entries left by a flush never show up.
    assign bus.o_data    = o_valid ? head.data : '0;
    assign bus.o_last    = o_valid & head.last;

`ifdef BRAM_RD_STATS_EN
    logic [31:0] stat_words_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else if (stat_clr_i) begin
            stat_words_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (pop && (stat_words_q != '1)) begin
                stat_words_q <= stat_words_q + 32'd1;
            end
            if (o_valid && !bus.o_ready && (stat_stalls_q != '1)) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_words_o  = stat_words_q;
    assign stat_stalls_o = stat_stalls_q;
`endif

endmodule

// File: tb/tb_bram_s2_burst_reader.sv
// Directed self-checking bench for bram_s2_burst_reader with a RAM model
// preloaded so that word k holds k mod 4.
module tb_bram_s2_burst_reader;

    logic clk = 1'b0;
    logic rst_n;
    logic abort;
    logic busy;

    bram_s2_burst_reader_if bus ();

`ifdef BRAM_RD_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_words;
    logic [31:0] stat_stalls;
`endif

    bram_s2_burst_reader dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .abort_i (abort),
        .busy_o  (busy)
`ifdef BRAM_RD_STATS_EN
        ,
        .stat_clr_i    (stat_clr),
        .stat_words_o  (stat_words),
        .stat_stalls_o (stat_stalls)
`endif
    );

    always #5 clk = ~clk;

    // RAM port model: registered read, 1-cycle latency.
    logic [1:0] ram [2048];
    always_ff @(posedge clk) begin
        if (bus.en) begin
            bus.dout <= ram[bus.addr];
        end
    end

    int n_run  = 0;
    int n_fail = 0;

    logic [1:0]  q_data [$];
    logic        q_last [$];
    logic [10:0] q_addr [$];
    int          first_valid, first_en, done_cyc, credit_viol, stab_viol, n_issue, n_pop;
    logic        done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_cmd(input logic [10:0] a, input logic [10:0] l);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Runs from the negedge after the handshake; cyc 0 is the cycle after it.
    // pat 0: always ready; 1: ready pattern 1,0,0,1; 2: stall cycles 3..5.
    task automatic collect(input int pat, input int max_cyc, input int abort_at);
        logic       prev_stall;
        logic [1:0] prev_data;
        logic       prev_last;
        logic       pop;
        q_data.delete();
        q_last.delete();
        q_addr.delete();
        first_valid = -1;
        first_en    = -1;
        done_cyc    = -1;
        credit_viol = 0;
        stab_viol   = 0;
        n_issue     = 0;
        n_pop       = 0;
        done        = 1'b0;
        prev_stall  = 1'b0;
        prev_data   = 2'd0;
        prev_last   = 1'b0;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            case (pat)
                1:       bus.o_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       bus.o_ready = !(cyc >= 3 && cyc <= 5);
                default: bus.o_ready = 1'b1;
            endcase
            #1;
            pop = bus.o_valid & bus.o_ready;
            if (prev_stall && !(bus.o_valid && bus.o_data == prev_data &&
                                bus.o_last == prev_last)) begin
                stab_viol++;
            end
            if (bus.en) begin
                if (n_issue - n_pop - (pop ? 1 : 0) >= 2) credit_viol++;
                if (first_en < 0) first_en = cyc;
                q_addr.push_back(bus.addr);
                n_issue++;
            end
            if (bus.o_valid && first_valid < 0) first_valid = cyc;
            if (pop) begin
                q_data.push_back(bus.o_data);
                q_last.push_back(bus.o_last);
                n_pop++;
                if (bus.o_last) begin
                    done     = 1'b1;
                    done_cyc = cyc;
                end
                if (abort_at != 0 && n_pop == abort_at) begin
                    abort    = 1'b1;
                    done     = 1'b1;
                    done_cyc = cyc;
                end
            end
            prev_stall = bus.o_valid && !bus.o_ready;
            prev_data  = bus.o_data;
            prev_last  = bus.o_last;
            if (!done) @(negedge clk);
        end
        chk("burst_done", 32'(done), 32'd1);
    endtask

    function automatic int count_last();
        int n = 0;
        foreach (q_last[i]) if (q_last[i]) n++;
        return n;
    endfunction

    initial begin
        logic [10:0] wrap_a [4];
        logic [1:0]  wrap_d [4];
        logic [1:0]  tail_d [3];
        int          bad;
        wrap_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        wrap_d = '{2'd2, 2'd3, 2'd0, 2'd1};
        tail_d = '{2'd3, 2'd0, 2'd1};

        for (int k = 0; k < 2048; k++) ram[k] = 2'(k % 4);
        rst_n         = 1'b0;
        abort         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.o_ready   = 1'b1;
`ifdef BRAM_RD_STATS_EN
        stat_clr = 1'b0;
`endif

        // Reset state
        #2;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_en",        32'(bus.en),        32'd0);
        chk("rst_addr",      32'(bus.addr),      32'd0);
        chk("rst_o_valid",   32'(bus.o_valid),   32'd0);
        chk("rst_o_data",    32'(bus.o_data),    32'd0);
        chk("rst_o_last",    32'(bus.o_last),    32'd0);
        chk("rst_busy",      32'(busy),          32'd0);
        chk("rst_we_rst",    32'({bus.we, bus.rst}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic burst: 0x010, 8 words
        start_cmd(11'h010, 11'd7);
        collect(0, 40, 0);
        chk("basic_first_en",    32'(first_en),    32'd0);
        chk("basic_first_valid", 32'(first_valid), 32'd2);
        chk("basic_done_cyc",    32'(done_cyc),    32'd9);
        chk("basic_count",       32'(q_data.size()), 32'd8);
        for (int i = 0; i < 8 && i < q_data.size(); i++)
            chk($sformatf("basic_data%0d", i), 32'(q_data[i]), 32'(i % 4));
        chk("basic_n_last", 32'(count_last()), 32'd1);
        if (q_last.size() == 8) chk("basic_last_pos", 32'(q_last[7]), 32'd1);
        @(negedge clk);
        chk("basic_busy_after",  32'(busy),          32'd0);
        chk("basic_ready_after", 32'(bus.cmd_ready), 32'd1);

        // Wrap-around at the top of the address space
        start_cmd(11'h7FE, 11'd3);
        collect(0, 40, 0);
        chk("wrap_n_addr", 32'(q_addr.size()), 32'd4);
        chk("wrap_n_data", 32'(q_data.size()), 32'd4);
        for (int i = 0; i < 4 && i < q_addr.size(); i++)
            chk($sformatf("wrap_addr%0d", i), 32'(q_addr[i]), 32'(wrap_a[i]));
        for (int i = 0; i < 4 && i < q_data.size(); i++)
            chk($sformatf("wrap_data%0d", i), 32'(q_data[i]), 32'(wrap_d[i]));

        // Backpressure: ready 1,0,0,1 over 16 words
        start_cmd(11'h100, 11'd15);
        collect(1, 200, 0);
        chk("bp_count", 32'(q_data.size()), 32'd16);
        bad = 0;
        foreach (q_data[i]) if (q_data[i] != 2'(i % 4)) bad++;
        chk("bp_data_errs",   32'(bad),         32'd0);
        chk("bp_credit_viol", 32'(credit_viol), 32'd0);
        chk("bp_stable_viol", 32'(stab_viol),   32'd0);
        chk("bp_n_last",      32'(count_last()), 32'd1);
        chk("bp_issues",      32'(n_issue),     32'd16);

        // Single word
        start_cmd(11'h005, 11'd0);
        collect(0, 20, 0);
        chk("single_issues", 32'(n_issue), 32'd1);
        chk("single_count",  32'(q_data.size()), 32'd1);
        if (q_data.size() == 1) begin
            chk("single_data", 32'(q_data[0]), 32'd1);
            chk("single_last", 32'(q_last[0]), 32'd1);
        end

        // Abort together with the 5th pop
        start_cmd(11'h000, 11'd100);
        collect(0, 40, 5);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_o_valid",   32'(bus.o_valid),   32'd0);
        chk("abort_en",        32'(bus.en),        32'd0);
        chk("abort_busy",      32'(busy),          32'd0);
        chk("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("abort_pops",      32'(n_pop),         32'd5);
        chk("abort_n_last",    32'(count_last()),  32'd0);
        repeat (3) @(negedge clk);
        chk("abort_quiet", 32'({bus.o_valid, bus.en}), 32'd0);

        // Normal burst after abort
        start_cmd(11'h003, 11'd2);
        collect(0, 20, 0);
        chk("post_abort_count", 32'(q_data.size()), 32'd3);
        for (int i = 0; i < 3 && i < q_data.size(); i++)
            chk($sformatf("post_abort_data%0d", i), 32'(q_data[i]), 32'(tail_d[i]));

        // Asynchronous reset in the middle of a 32-word burst
        bus.o_ready = 1'b1;
        start_cmd(11'h000, 11'd31);
        repeat (6) @(negedge clk);
        chk("pre_rst_valid", 32'(bus.o_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_o_valid",   32'(bus.o_valid),   32'd0);
        chk("mrst_en",        32'(bus.en),        32'd0);
        chk("mrst_busy",      32'(busy),          32'd0);
        chk("mrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("mrst_addr",      32'(bus.addr),      32'd0);
        chk("mrst_o_data",    32'({bus.o_data, bus.o_last}), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.o_valid || bus.en || !bus.cmd_ready) bad++;
        end
        chk("mrst_after_release", 32'(bad), 32'd0);
        start_cmd(11'h00A, 11'd1);
        collect(0, 20, 0);
        chk("mrst_next_count", 32'(q_data.size()), 32'd2);
        if (q_data.size() == 2) chk("mrst_next_data", 32'({q_data[0], q_data[1]}), 32'hB);

`ifdef BRAM_RD_STATS_EN
        // Statistics: 10 words with 3 stall cycles
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_cleared", stat_words | stat_stalls, 32'd0);
        start_cmd(11'h020, 11'd9);
        collect(2, 40, 0);
        @(negedge clk);
        chk("stat_words",  stat_words,  32'd10);
        chk("stat_stalls", stat_stalls, 32'd3);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr_words",  stat_words,  32'd0);
        chk("stat_clr_stalls", stat_stalls, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
